// File: rtl/mem_io_bridge_pkg.sv
// Shared address map and encodings for the memory/IO bridge.
// Used by the bridge RTL and by the software test images.
package mem_io_bridge_pkg;

  localparam int unsigned RAM_WORDS_DEF = 512;
  localparam logic [31:0] IO_BASE_ADDR  = 32'hFFFF_FF00;

  // I/O register byte offsets from the I/O base
  localparam logic [31:0] OFS_SWITCH = 32'h0000_0000;
  localparam logic [31:0] OFS_LED    = 32'h0000_0004;
  localparam logic [31:0] OFS_CYCLE  = 32'h0000_0008;

  // First byte address past the RAM window for the default depth
  localparam logic [31:0] RAM_LIMIT  = 32'h0000_0800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    RG_RAM    = 3'd0,
    RG_SWITCH = 3'd1,
    RG_LED    = 3'd2,
    RG_CYCLE  = 3'd3,
    RG_NONE   = 3'd4
  } region_t;

  // Region decode of a byte address; the low two bits are ignored so a
  // misaligned access lands on the word that contains it.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] io_base,
                                            input logic [31:0] ram_bytes);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (a < ram_bytes)                   return RG_RAM;
    else if (a == io_base + OFS_SWITCH)  return RG_SWITCH;
    else if (a == io_base + OFS_LED)     return RG_LED;
    else if (a == io_base + OFS_CYCLE)   return RG_CYCLE;
    else                                 return RG_NONE;
  endfunction

endpackage

// File: rtl/mem_io_bridge_io_regs.sv
// Memory-mapped I/O registers: LED register, free-running cycle counter
// and the read mux, with the read value captured at the end of ACC.
// Ports:
//   clk, rst      clock, async active-high reset
//   acc           bridge is in its ACC cycle (writes/capture happen on its exit edge)
//   we            latched write flag of the current access
//   region        latched region decode of the current access
//   wdata         low bits of the latched write data (LED payload)
//   switch        board switches
//   led           LED register
//   rdata         captured I/O read value
module mem_io_bridge_io_regs
  import mem_io_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,
  input  logic        we,
  input  region_t     region,
  input  logic [3:0]  wdata,
  input  logic [6:0]  switch,
  output logic [3:0]  led,
  output logic [31:0] rdata
);

  logic [31:0] cycle;
  logic [31:0] rd_c;

  // Read mux over the I/O registers; unmapped and RAM regions read 0 here
  always_comb begin
    rd_c = '0;
    case (region)
      RG_SWITCH: rd_c = {25'b0, switch};
      RG_LED:    rd_c = {28'b0, led};
      RG_CYCLE:  rd_c = cycle;
      default:   rd_c = '0;
    endcase
  end

  // Counter: clearing write wins over the increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle <= '0;
    end else if (acc && we && (region == RG_CYCLE)) begin
      cycle <= '0;
    end else begin
      cycle <= 32'(cycle + 32'd1);
    end
  end

  // LED write and read capture, both on the ACC exit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led   <= '0;
      rdata <= '0;
    end else if (acc) begin
      if (we && (region == RG_LED)) led <= wdata;
      if (!we)                      rdata <= rd_c;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: fixed 3-cycle request/ready handshake from the CPU to a
// synchronous block RAM and a small I/O register window.
// Ports:
//   clk, rst               clock, async active-high reset
//   cpu_req/we/addr/wdata  CPU access request (req held until cpu_ready)
//   cpu_rdata, cpu_ready   read data (0 unless ready) and completion pulse
//   ram_addr/we/wdata      block RAM port (word address, write strobe, data)
//   ram_rdata              RAM read data, one cycle after ram_addr is sampled
//   switch                 board switches (read-only)
//   led                    LED register
//   err                    sticky unmapped/misaligned access flag
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEF,
  parameter logic [31:0] IO_BASE   = IO_BASE_ADDR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  output logic [31:0]                  cpu_rdata,
  output logic                         cpu_ready,
  output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
  output logic                         ram_we,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata,
  input  logic [6:0]                   switch,
  output logic [3:0]                   led,
  output logic                         err
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  state_t      state;
  region_t     region;
  region_t     region_dec_c;
  logic        acc_we;
  logic        acc_c;
  logic [31:0] io_rdata;

  assign region_dec_c = decode_region(cpu_addr, IO_BASE, RAM_BYTES);
  assign acc_c        = (state == ST_ACC);

  // Bridge FSM; the whole access is latched on the IDLE->ACC edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      region    <= RG_NONE;
      acc_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      cpu_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_req) begin
            state     <= ST_ACC;
            region    <= region_dec_c;
            acc_we    <= cpu_we;
            ram_addr  <= cpu_addr[AW+1:2];
            ram_wdata <= cpu_wdata;
            ram_we    <= cpu_we && (region_dec_c == RG_RAM);
            if ((cpu_addr[1:0] != 2'b00) || (region_dec_c == RG_NONE)) err <= 1'b1;
          end
        end
        ST_ACC: begin
          ram_we    <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          cpu_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          ram_we    <= 1'b0;
          cpu_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM data arrives during RESP straight from the RAM, so it is muxed here
  always_comb begin
    cpu_rdata = '0;
    if (cpu_ready) cpu_rdata = (region == RG_RAM) ? ram_rdata : io_rdata;
  end

  mem_io_bridge_io_regs u_io (
    .clk    (clk),
    .rst    (rst),
    .acc    (acc_c),
    .we     (acc_we),
    .region (region),
    .wdata  (ram_wdata[3:0]),
    .switch (switch),
    .led    (led),
    .rdata  (io_rdata)
  );

endmodule
